mult_unit: RTL

- Iterative shift-add multiplier with architectural HI/LO registers for the single-cycle MIPS core.
- Sits directly downstream of the datapath's register-read stage. It consumes rs/rt operands for mult/multu and supplies HI/LO for mfhi/mflo.
- The controller stalls the PC while busy is high.
- Exercised by the processor testbench's multiplication programs, which check GPR contents after a fixed cycle count.

---
 rtl/mult_unit_if.sv | 25 ++
 rtl/mult_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/mult_unit_if.sv
// rtl/mult_unit_if.sv - operand, HI/LO move and result bundle of the MIPS multiplier
`timescale 1ns/1ps
interface mult_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, mthi, mtlo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, mthi, mtlo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative shift-add multiplier with architectural HI/LO registers
`timescale 1ns/1ps
module mult_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  mult_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // The most negative value negates to itself, which is the correct unsigned magnitude.
  assign mag_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign mag_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.wr_data;
          if (bus.mtlo) lo_q <= bus.wr_data;
          if (bus.start) begin
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            neg     <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc     <= '0;
            counter <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CW'(1);
          if (counter == LAST) state <= DONE;
        end
        DONE: begin
          {hi_q, lo_q} <= neg ? -acc : acc;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
